// File: rtl/npc_fetch_if.sv
// Instruction-memory read port between the fetch unit and the instruction store.
// The fetch side drives the request and address; memory answers with ack and data.
interface npc_fetch_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/npc_fetch.sv
// Two-state fetch/execute sequencer: reads one instruction, holds it for execute,
// then retires it by loading the next PC selected by NPCOp and the ALU flags.
module npc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        NPCOp,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [31:0]       rs_data,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              hold,
    npc_fetch_if.master       imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       PC,
    output logic [31:0]       PC4,
    output logic              addr_err,
    output logic [31:0]       icount
);

    localparam logic [3:0] NPC_PLUS4 = 4'd0;
    localparam logic [3:0] NPC_BEQ   = 4'd1;
    localparam logic [3:0] NPC_BNE   = 4'd2;
    localparam logic [3:0] NPC_BGTZ  = 4'd3;
    localparam logic [3:0] NPC_BLEZ  = 4'd4;
    localparam logic [3:0] NPC_BLTZ  = 4'd5;
    localparam logic [3:0] NPC_BGEZ  = 4'd6;
    localparam logic [3:0] NPC_JUMP  = 4'd7;
    localparam logic [3:0] NPC_JUMPR = 4'd8;

    typedef enum logic [0:0] {StFetch, StExec} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] icount_q, icount_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic        br_taken;
    logic [31:0] target;

    assign pc4         = pc_q + 32'd4;
    assign br_off      = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target   = pc4 + br_off;
    assign jump_target = {pc4[31:28], imm26, 2'b00};

    // Branch condition from the flags the ALU produced for this instruction.
    always_comb begin
        br_taken = 1'b0;
        unique case (NPCOp)
            NPC_BEQ:  br_taken = alu_zero;
            NPC_BNE:  br_taken = !alu_zero;
            NPC_BGTZ: br_taken = !alu_zero && !alu_neg;
            NPC_BLEZ: br_taken = alu_zero || alu_neg;
            NPC_BLTZ: br_taken = alu_neg;
            NPC_BGEZ: br_taken = !alu_neg;
            default:  br_taken = 1'b0;
        endcase
    end

    // Unknown selector codes fall back to sequential flow.
    always_comb begin
        target = pc4;
        unique case (NPCOp)
            NPC_PLUS4: target = pc4;
            NPC_BEQ, NPC_BNE, NPC_BGTZ,
            NPC_BLEZ, NPC_BLTZ, NPC_BGEZ:
                       target = br_taken ? br_target : pc4;
            NPC_JUMP:  target = jump_target;
            NPC_JUMPR: target = rs_data;
            default:   target = pc4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        icount_d   = icount_q;
        addr_err_d = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (imem.im_ack) begin
                    instr_d = imem.im_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!hold) begin
                    // Misaligned targets are forced onto a word boundary and flagged.
                    pc_d       = {target[31:2], 2'b00};
                    addr_err_d = |target[1:0];
                    icount_d   = icount_q + 32'd1;
                    state_d    = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            icount_q   <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            icount_q   <= icount_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Request is gated by reset so it drops the moment reset asserts.
    assign imem.im_req  = (state_q == StFetch) && rstn;
    assign imem.im_addr = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = (state_q == StExec);
    assign PC           = pc_q;
    assign PC4          = pc4;
    assign addr_err     = addr_err_q;
    assign icount       = icount_q;

    exit_retires_one: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == StExec && !hold) |=> (icount_q == $past(icount_q) + 32'd1));

    hold_freezes: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == StExec && hold) |=>
        (state_q == StExec && $stable(pc_q) && $stable(instr_q) && $stable(icount_q)));

    exit_aligns_pc: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == StExec && !hold) |=> (pc_q[1:0] == 2'b00));

    err_single_pulse: assert property (@(posedge clk) disable iff (!rstn)
        addr_err_q |=> !addr_err_q);

endmodule

// File: tb/tb_npc_fetch.sv
// Randomised bench for npc_fetch against an architectural model of the fetch unit,
// with directed sequences whose results are pinned by hand-computed literals.
module tb_npc_fetch;

    localparam logic [3:0] NPC_PLUS4 = 4'd0;
    localparam logic [3:0] NPC_BEQ   = 4'd1;
    localparam logic [3:0] NPC_BNE   = 4'd2;
    localparam logic [3:0] NPC_BGTZ  = 4'd3;
    localparam logic [3:0] NPC_BLEZ  = 4'd4;
    localparam logic [3:0] NPC_BLTZ  = 4'd5;
    localparam logic [3:0] NPC_BGEZ  = 4'd6;
    localparam logic [3:0] NPC_JUMP  = 4'd7;
    localparam logic [3:0] NPC_JUMPR = 4'd8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  NPCOp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        alu_zero, alu_neg, hold;
    logic [31:0] instr, PC, PC4, icount;
    logic        instr_valid, addr_err;
    logic [31:0] instr_b, PC_b, PC4_b, icount_b;
    logic        instr_valid_b, addr_err_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    npc_fetch_if bus ();
    npc_fetch_if bus2 ();
    assign bus2.im_ack   = bus.im_ack;
    assign bus2.im_rdata = bus.im_rdata;

    npc_fetch dut (
        .clk(clk), .rstn(rstn), .NPCOp(NPCOp), .imm16(imm16), .imm26(imm26),
        .rs_data(rs_data), .alu_zero(alu_zero), .alu_neg(alu_neg), .hold(hold),
        .imem(bus.master), .instr(instr), .instr_valid(instr_valid), .PC(PC),
        .PC4(PC4), .addr_err(addr_err), .icount(icount)
    );

    npc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rstn(rstn), .NPCOp(NPCOp), .imm16(imm16), .imm26(imm26),
        .rs_data(rs_data), .alu_zero(alu_zero), .alu_neg(alu_neg), .hold(hold),
        .imem(bus2.master), .instr(instr_b), .instr_valid(instr_valid_b), .PC(PC_b),
        .PC4(PC4_b), .addr_err(addr_err_b), .icount(icount_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Next PC from the instruction-set rules, before word alignment.
    function automatic logic [31:0] ref_target(input logic [3:0] op, input logic [31:0] pc,
                                               input logic [15:0] off, input logic [25:0] idx,
                                               input logic [31:0] rs, input logic z,
                                               input logic n);
        logic [31:0] seq;
        logic [31:0] br;
        bit          taken;
        seq   = pc + 32'd4;
        br    = seq + 32'(int'($signed(off)) * 4);
        taken = 1'b0;
        case (op)
            NPC_BEQ:   taken = z;
            NPC_BNE:   taken = !z;
            NPC_BGTZ:  taken = !z && !n;
            NPC_BLEZ:  taken = z || n;
            NPC_BLTZ:  taken = n;
            NPC_BGEZ:  taken = !n;
            NPC_JUMP:  return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
            NPC_JUMPR: return rs;
            default:   taken = 1'b0;
        endcase
        return taken ? br : seq;
    endfunction

    // Architectural model: holding an instruction or waiting for one.
    logic [31:0] m_pc, m_icount, m_instr, nt;
    bit          m_have, m_err;

    assign nt = ref_target(NPCOp, m_pc, imm16, imm26, rs_data, alu_zero, alu_neg);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc     <= 32'h0000_3000;
            m_icount <= 32'd0;
            m_instr  <= 32'd0;
            m_have   <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (!m_have) begin
                if (bus.im_ack) begin
                    m_instr <= bus.im_rdata;
                    m_have  <= 1'b1;
                end
            end else if (!hold) begin
                m_pc     <= nt - (nt % 32'd4);
                m_err    <= (nt % 32'd4) != 32'd0;
                m_icount <= m_icount + 32'd1;
                m_have   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("im_req", 32'(bus.im_req), 32'(!m_have && rstn));
            cmp("im_addr", bus.im_addr, m_pc);
            cmp("instr", instr, m_instr);
            cmp("instr_valid", 32'(instr_valid), 32'(m_have));
            cmp("PC", PC, m_pc);
            cmp("PC4", PC4, m_pc + 32'd4);
            cmp("addr_err", 32'(addr_err), 32'(m_err));
            cmp("icount", icount, m_icount);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Fetch one instruction, then retire it with the given next-PC controls.
    task automatic run_op(input logic [3:0] op, input logic [15:0] i16, input logic [25:0] i26,
                          input logic [31:0] rs, input logic z, input logic n);
        bus.im_ack   = 1'b1;
        bus.im_rdata = $urandom;
        step();
        bus.im_ack = 1'b0;
        NPCOp      = op;
        imm16      = i16;
        imm26      = i26;
        rs_data    = rs;
        alu_zero   = z;
        alu_neg    = n;
        hold       = 1'b0;
        step();
        NPCOp = NPC_PLUS4;
    endtask

    int req_cnt;
    int val_cnt;

    initial begin
        rstn = 1'b0; NPCOp = NPC_PLUS4; imm16 = '0; imm26 = '0; rs_data = '0;
        alu_zero = 1'b0; alu_neg = 1'b0; hold = 1'b0;
        bus.im_ack = 1'b0; bus.im_rdata = '0;
        repeat (3) step();
        chk_en = 1'b1;
        cmp("rst_pc", PC, 32'h0000_3000);
        cmp("rst_req", 32'(bus.im_req), 32'd0);
        cmp("rst_valid", 32'(instr_valid), 32'd0);
        cmp("rst_icount", icount, 32'd0);
        cmp("rst_instr", instr, 32'd0);

        // Release with ack in the same cycle the request rises.
        rstn = 1'b1; bus.im_ack = 1'b1; bus.im_rdata = 32'h2008_0005;
        #1;
        cmp("rel_req", 32'(bus.im_req), 32'd1);
        cmp("rel_addr", bus.im_addr, 32'h0000_3000);
        step();
        cmp("exec_instr", instr, 32'h2008_0005);
        cmp("exec_valid", 32'(instr_valid), 32'd1);
        bus.im_rdata = 32'hDEAD_BEEF;
        step();
        cmp("plus4_pc", PC, 32'h0000_3004);
        cmp("plus4_icount", icount, 32'd1);
        cmp("plus4_valid", 32'(instr_valid), 32'd0);
        cmp("exec_ack_ignored", instr, 32'h2008_0005);
        cmp("wrap_pc", PC_b, 32'd0);
        cmp("wrap_pc4", PC4_b, 32'd4);
        cmp("wrap_icount", icount_b, 32'd1);
        cmp("wrap_instr", instr_b, 32'h2008_0005);
        cmp("wrap_valid", 32'(instr_valid_b), 32'd0);
        cmp("wrap_err", 32'(addr_err_b), 32'd0);

        run_op(NPC_JUMPR, 16'h0, 26'h0, 32'h0000_3010, 1'b0, 1'b0);
        cmp("jr_pc", PC, 32'h0000_3010);
        run_op(NPC_BEQ, 16'hFFFC, 26'h0, 32'h0, 1'b1, 1'b0);
        cmp("beq_taken_pc", PC, 32'h0000_3004);
        run_op(NPC_JUMPR, 16'h0, 26'h0, 32'h0000_3010, 1'b0, 1'b0);
        run_op(NPC_BEQ, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0);
        cmp("beq_fall_pc", PC, 32'h0000_3014);

        run_op(NPC_JUMPR, 16'h0, 26'h0, 32'h0000_3020, 1'b0, 1'b0);
        bus.im_ack = 1'b1;
        step();
        cmp("jal_pc4", PC4, 32'h0000_3024);
        bus.im_ack = 1'b0; NPCOp = NPC_JUMP; imm26 = 26'h000_0C10;
        step();
        NPCOp = NPC_PLUS4;
        cmp("jal_pc", PC, 32'h0000_3040);

        run_op(NPC_JUMPR, 16'h0, 26'h0, 32'h0000_3002, 1'b0, 1'b0);
        cmp("jr_mis_pc", PC, 32'h0000_3000);
        cmp("jr_mis_err", 32'(addr_err), 32'd1);
        step();
        cmp("jr_mis_err_clr", 32'(addr_err), 32'd0);

        // Slow memory plus a held execute: one retirement only.
        req_cnt = 0; val_cnt = 0;
        repeat (3) begin
            req_cnt += int'(bus.im_req); val_cnt += int'(instr_valid);
            step();
        end
        bus.im_ack = 1'b1; bus.im_rdata = 32'h1234_5678;
        req_cnt += int'(bus.im_req); val_cnt += int'(instr_valid);
        step();
        bus.im_ack = 1'b0; hold = 1'b1;
        repeat (2) begin
            req_cnt += int'(bus.im_req); val_cnt += int'(instr_valid);
            step();
        end
        hold = 1'b0;
        req_cnt += int'(bus.im_req); val_cnt += int'(instr_valid);
        step();
        cmp("slow_req_cycles", 32'(req_cnt), 32'd4);
        cmp("slow_valid_cycles", 32'(val_cnt), 32'd3);
        cmp("slow_icount", icount, 32'd9);
        cmp("slow_pc", PC, 32'h0000_3004);
        cmp("slow_instr", instr, 32'h1234_5678);

        // Asynchronous reset while execute is held.
        bus.im_ack = 1'b1;
        step();
        bus.im_ack = 1'b0; hold = 1'b1;
        step();
        rstn = 1'b0;
        #1;
        cmp("arst_pc", PC, 32'h0000_3000);
        cmp("arst_icount", icount, 32'd0);
        cmp("arst_valid", 32'(instr_valid), 32'd0);
        cmp("arst_req", 32'(bus.im_req), 32'd0);
        cmp("arst_instr", instr, 32'd0);
        step();
        rstn = 1'b1; hold = 1'b0;
        #1;
        cmp("refetch_req", 32'(bus.im_req), 32'd1);
        cmp("refetch_addr", bus.im_addr, 32'h0000_3000);

        for (int i = 0; i < 3000; i++) begin
            bus.im_ack   = ($urandom_range(0, 3) != 0);
            bus.im_rdata = $urandom;
            NPCOp        = 4'($urandom_range(0, 15));
            imm16        = 16'($urandom);
            imm26        = 26'($urandom);
            rs_data      = $urandom;
            if ($urandom_range(0, 3) != 0) rs_data = rs_data & 32'hFFFF_FFFC;
            alu_zero     = 1'($urandom);
            alu_neg      = 1'($urandom);
            hold         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end else begin
                step();
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/npc_fetch.md
NPC_FETCH -- requirements
Module: npc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 NPCOp  input  4  next-PC selector from control decode; values per `NPC_* macros in ctrl_encode_def.v.
REQ-005 imm16  input  16  branch offset, instr[15:0].
REQ-006 imm26  input  26  jump index, instr[25:0].
REQ-007 rs_data  input  32  register rs value for NPC_JUMPR.
REQ-008 alu_zero  input  1  ALU result == 0 (SUB for BEQ/BNE, SUBZ for the others).
REQ-009 alu_neg  input  1  ALU result bit 31.
REQ-010 hold  input  1  downstream stall; freezes EXEC.
REQ-011 im_req  output  1  instruction-memory read request.
REQ-012 im_addr  output  32  instruction-memory address, equals PC.
REQ-013 im_ack  input  1  memory returns im_rdata this cycle.
REQ-014 im_rdata  input  32  instruction word.
REQ-015 instr  output  32  latched instruction register to decode.
REQ-016 instr_valid  output  1  instr and PC valid for decode/execute.
REQ-017 PC  output  32  address of current instruction.
REQ-018 PC4  output  32  PC+4, feeds NPC2REG writeback path.
REQ-019 addr_err  output  1  one-cycle pulse on misaligned target.
REQ-020 icount  output  32  retired-instruction counter.

Function
REQ-021 FSM states FETCH and EXEC; reset enters FETCH.
REQ-022 FETCH: im_req=1, im_addr=PC; on im_ack=1 latch im_rdata into instr, go EXEC next cycle; im_ack may arrive in the same cycle im_req rises.
REQ-023 im_ack while in EXEC or during reset is ignored; instr unchanged.
REQ-024 EXEC: im_req=0, instr_valid=1; hold=1 keeps EXEC with PC, instr, icount unchanged.
REQ-025 EXEC with hold=0: PC <= next target, icount <= icount+1, state <= FETCH; one instruction retires per EXEC exit.
REQ-026 Minimum instruction period 2 cycles (ack in first FETCH cycle); each extra ack wait adds 1.
REQ-027 Target: PLUS4 -> PC+4; BEQ taken if alu_zero; BNE if !alu_zero; BGTZ if !alu_zero&&!alu_neg; BLEZ if alu_zero||alu_neg; BLTZ if alu_neg; BGEZ if !alu_neg.
REQ-028 Taken branch target = PC+4 + (sign_extend(imm16) << 2), 32-bit modulo; not taken -> PC+4.
REQ-029 NPC_JUMP target = {PC4[31:28], imm26, 2'b00}; NPC_JUMPR target = rs_data.
REQ-030 Any undefined NPCOp value treated as PLUS4.
REQ-031 Target with bits[1:0] != 0: PC <= {target[31:2], 2'b00}, addr_err=1 for the cycle after the update, else 0.
REQ-032 All adds wrap modulo 2^32 (PC 32'hFFFF_FFFC + 4 -> 0); icount wraps 32'hFFFF_FFFF -> 0.
REQ-033 No branch delay slot; PC4 is combinational PC+4 at all times.

Reset
REQ-034 rstn=0 immediately forces: PC=RESET_PC, state=FETCH, instr=0, instr_valid=0, im_req=0, addr_err=0, icount=0.
REQ-035 Reset mid-FETCH or mid-EXEC aborts without retirement; first cycle after release asserts im_req with im_addr=RESET_PC.

Verification
REQ-036 Release reset, im_ack same cycle, instr 32'h2008_0005, NPCOp=PLUS4 -> instr_valid 1 cycle, PC 3000 -> 3004, icount=1.
REQ-037 BEQ at PC 3010, imm16=16'hFFFC, alu_zero=1 -> PC=3004; same with alu_zero=0 -> PC=3014.
REQ-038 JAL imm26=26'h000_0C10 at PC 3020 -> PC=0000_3040, PC4=3024 during EXEC; JR rs_data=32'h0000_3002 -> PC=3000, addr_err pulses 1 cycle.
REQ-039 im_ack delayed 3 cycles then hold=1 for 2 EXEC cycles -> im_req high 4 cycles, instr_valid high 3 cycles, icount +1 only.
REQ-040 rstn low during EXEC with hold=1 -> outputs reset asynchronously, icount=0, refetch from 3000.
REQ-041 PC preset via RESET_PC=32'hFFFF_FFFC, PLUS4 -> PC=0; icount preloaded near wrap by 2^32 retirements is skipped, checked by formal assertion instead.
